// File: rtl/lfsr_mult_driver.sv
// LFSR operand generator and signature collector for the shift-add multiplier.
// Ports: clk, rst (sync, active-high); go/num_ops start a run; m_out/n_out/
// mult_start drive the multiplier, mult_busy/mult_prod return from it;
// signature, ops_done, running, done, err report run status.
module lfsr_mult_driver #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [15:0] TAPS     = 16'hB400,
    parameter int          CNT_W    = 8,
    parameter int          BUSY_TMO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [CNT_W-1:0] num_ops,
    output logic [15:0]      m_out,
    output logic [15:0]      n_out,
    output logic             mult_start,
    input  logic             mult_busy,
    input  logic [15:0]      mult_prod,
    output logic [15:0]      signature,
    output logic [CNT_W-1:0] ops_done,
    output logic             running,
    output logic             done,
    output logic             err
);

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [15:0] SEED_NZ =
        (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int TMO_W = $clog2(BUSY_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(BUSY_TMO);

    typedef enum logic [2:0] {
        IDLE,
        GEN_M,
        GEN_N,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_step;
    logic [CNT_W-1:0] num_ops_q;
    logic [CNT_W-1:0] ops_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_hit;

    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS)
                               : (lfsr >> 1);
    assign ops_inc   = ops_done + CNT_W'(1);
    assign tmo_inc   = tmo_cnt + TMO_W'(1);
    assign tmo_hit   = (state == WAIT_HI) && !mult_busy
                    && (tmo_inc == TMO_MAX);

    always_comb begin
        state_nx   = state;
        mult_start = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx = (num_ops == '0) ? DONE : GEN_M;
                end
            end
            GEN_M: state_nx = GEN_N;
            GEN_N: state_nx = ISSUE;
            ISSUE: begin
                mult_start = 1'b1;
                state_nx   = WAIT_HI;
            end
            WAIT_HI: begin
                if (mult_busy) begin
                    state_nx = WAIT_LO;
                end else if (tmo_hit) begin
                    state_nx = DONE;
                end
            end
            WAIT_LO: begin
                if (!mult_busy) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nx = (ops_inc == num_ops_q) ? DONE : GEN_M;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_NZ;
            m_out     <= '0;
            n_out     <= '0;
            signature <= '0;
            ops_done  <= '0;
            num_ops_q <= '0;
            tmo_cnt   <= '0;
            running   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        num_ops_q <= num_ops;
                        lfsr      <= SEED_NZ;
                        signature <= '0;
                        ops_done  <= '0;
                        err       <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                GEN_M: begin
                    lfsr  <= lfsr_step;
                    m_out <= lfsr_step;
                end
                GEN_N: begin
                    lfsr  <= lfsr_step;
                    n_out <= lfsr_step;
                end
                ISSUE: tmo_cnt <= '0;
                WAIT_HI: begin
                    if (!mult_busy) begin
                        tmo_cnt <= tmo_inc;
                    end
                    if (tmo_hit) begin
                        err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // Rotate-left then fold in the product (MISR style).
                    signature <= {signature[14:0], signature[15]}
                               ^ mult_prod;
                    ops_done  <= ops_inc;
                end
                DONE: running <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
